ber_checker: RTL and testbench

- Receive-side checker of the BERT. It consumes the 8-bit stream after the error-injection stage.
- It self-synchronises a local PRBS-7 reference to the incoming bytes, then compares each byte with the reference.
- It accumulates bit-error and bit-total counts for BER readout.
- It detects loss of sync and returns to search automatically.

---
 rtl/bert_pkg.sv | 40 ++++
 rtl/ber_sat_acc.sv | 39 +++
 rtl/ber_checker.sv | 193 +++++++++++++++++++
 tb/tb_ber_checker.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bert_pkg.sv
// Shared BERT definitions: PRBS-7 geometry, checker state encoding and
// the byte-wide PRBS predictor / popcount helpers used by generator and checker.
package bert_pkg;

    localparam int PRBS_ORDER = 7;
    localparam int BYTE_W     = 8;
    // Tap lags of s[n] = s[n-6] ^ s[n-7]
    localparam int PRBS_TAP_A = 7;
    localparam int PRBS_TAP_B = 6;

    typedef enum logic [0:0] {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } ber_state_e;

    // Next BYTE_W stream bits after seed7 (seed bit 6 oldest); result bit 7 is earliest.
    function automatic logic [BYTE_W-1:0] prbs7_next8(input logic [PRBS_ORDER-1:0] seed7);
        logic [PRBS_ORDER-1:0] sr;
        logic [BYTE_W-1:0]     res;
        logic                  nb;
        sr  = seed7;
        res = {BYTE_W{1'b0}};
        for (int i = BYTE_W - 1; i >= 0; i--) begin
            nb     = sr[PRBS_TAP_A-1] ^ sr[PRBS_TAP_B-1];
            res[i] = nb;
            sr     = {sr[PRBS_ORDER-2:0], nb};
        end
        return res;
    endfunction

    function automatic logic [3:0] popcount8(input logic [BYTE_W-1:0] b);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < BYTE_W; i++) begin
            cnt = cnt + {3'b000, b[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/ber_sat_acc.sv
// Saturating accumulator: clear has priority, en adds 'add', result clamps at all-ones.
module ber_sat_acc #(
    parameter int CNT_W = 32,
    parameter int ADD_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic [ADD_W-1:0] add,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W:0]   sum_s;
    logic [CNT_W-1:0] count_r;

    // One extra bit catches the carry so a partial add can clamp instead of wrapping
    always_comb begin
        sum_s = {1'b0, count_r} + {{(CNT_W + 1 - ADD_W){1'b0}}, add};
    end

    // Counter register with clear-over-accumulate priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (en) begin
            if (sum_s[CNT_W]) begin
                count_r <= {CNT_W{1'b1}};
            end else begin
                count_r <= sum_s[CNT_W-1:0];
            end
        end
    end

    assign count = count_r;

endmodule

// File: rtl/ber_checker.sv
// BERT receive checker: self-synchronises a PRBS-7 reference to the incoming
// bytes, then counts bit errors and checked bits, dropping back to search on sync loss.
module ber_checker
    import bert_pkg::*;
#(
    parameter int LOCK_CNT = 8,
    parameter int LOSS_CNT = 4,
    parameter int ERR_THR  = 3,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       din,
    input  logic             din_valid,
    input  logic             clear,
    output logic             locked,
    output logic [3:0]       byte_err,
    output logic             byte_err_valid,
    output logic             sync_lost,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);

    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int LOSS_W  = $clog2(LOSS_CNT + 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
    localparam logic [LOSS_W-1:0]  LOSS_LAST  = LOSS_W'(LOSS_CNT - 1);
    localparam logic [3:0]         ERR_THR_V  = 4'(ERR_THR);

    ber_state_e           state_r;
    ber_state_e           state_nx_s;
    logic [6:0]           prev_din_r;
    logic [6:0]           lfsr_r;
    logic [MATCH_W-1:0]   match_cnt_r;
    logic [LOSS_W-1:0]    loss_cnt_r;
    logic [3:0]           byte_err_r;
    logic                 byte_err_valid_r;
    logic                 sync_lost_r;
    logic                 locked_r;

    logic [7:0]           exp_s;
    logic [3:0]           err_pop_s;
    logic                 match_s;
    logic                 bad_s;
    logic                 lock_ev_s;
    logic                 loss_ev_s;
    logic                 acc_en_s;

    // Reference byte: predicted from received history in SEARCH, from the free-running LFSR when LOCKED
    always_comb begin
        if (state_r == LOCKED) begin
            exp_s = prbs7_next8(lfsr_r);
        end else begin
            exp_s = prbs7_next8(prev_din_r);
        end
        err_pop_s = popcount8(din ^ exp_s);
        match_s   = (din == exp_s) && (prev_din_r != 7'h00);
        bad_s     = (err_pop_s >= ERR_THR_V);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= SEARCH;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            SEARCH: begin
                if (din_valid && match_s && (match_cnt_r == MATCH_LAST)) begin
                    state_nx_s = LOCKED;
                end else begin
                    state_nx_s = SEARCH;
                end
            end
            LOCKED: begin
                if (din_valid && bad_s && (loss_cnt_r == LOSS_LAST)) begin
                    state_nx_s = SEARCH;
                end else begin
                    state_nx_s = LOCKED;
                end
            end
            default: state_nx_s = SEARCH;
        endcase
    end

    // Transition and accumulate strobes
    always_comb begin
        lock_ev_s = 1'b0;
        loss_ev_s = 1'b0;
        acc_en_s  = 1'b0;
        case (state_r)
            SEARCH: begin
                lock_ev_s = (state_nx_s == LOCKED);
            end
            LOCKED: begin
                loss_ev_s = (state_nx_s == SEARCH);
                acc_en_s  = din_valid;
            end
            default: begin
                lock_ev_s = 1'b0;
            end
        endcase
    end

    // Sync datapath: history, reference LFSR and the match / loss run counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_din_r  <= 7'h00;
            lfsr_r      <= 7'h00;
            match_cnt_r <= {MATCH_W{1'b0}};
            loss_cnt_r  <= {LOSS_W{1'b0}};
        end else if (din_valid) begin
            if (state_r == SEARCH) begin
                prev_din_r <= din[6:0];
                if (lock_ev_s) begin
                    lfsr_r      <= din[6:0];
                    match_cnt_r <= {MATCH_W{1'b0}};
                end else if (match_s) begin
                    match_cnt_r <= match_cnt_r + {{(MATCH_W - 1){1'b0}}, 1'b1};
                end else begin
                    match_cnt_r <= {MATCH_W{1'b0}};
                end
            end else begin
                // The reference free-runs; received data is never fed back while locked
                lfsr_r <= exp_s[6:0];
                if (loss_ev_s) begin
                    prev_din_r  <= din[6:0];
                    match_cnt_r <= {MATCH_W{1'b0}};
                    loss_cnt_r  <= {LOSS_W{1'b0}};
                end else if (bad_s) begin
                    loss_cnt_r <= loss_cnt_r + {{(LOSS_W - 1){1'b0}}, 1'b1};
                end else begin
                    loss_cnt_r <= {LOSS_W{1'b0}};
                end
            end
        end
    end

    // Registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_err_r       <= 4'd0;
            byte_err_valid_r <= 1'b0;
            sync_lost_r      <= 1'b0;
            locked_r         <= 1'b0;
        end else begin
            byte_err_valid_r <= acc_en_s;
            sync_lost_r      <= din_valid && loss_ev_s;
            locked_r         <= (state_nx_s == LOCKED);
            if (acc_en_s) begin
                byte_err_r <= err_pop_s;
            end else if (state_r == SEARCH) begin
                byte_err_r <= 4'd0;
            end
        end
    end

    ber_sat_acc #(
        .CNT_W (CNT_W),
        .ADD_W (4)
    ) u_err_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .en    (acc_en_s),
        .add   (err_pop_s),
        .count (err_count)
    );

    ber_sat_acc #(
        .CNT_W (CNT_W),
        .ADD_W (4)
    ) u_bit_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .en    (acc_en_s),
        .add   (4'd8),
        .count (bit_count)
    );

    assign locked         = locked_r;
    assign byte_err       = byte_err_r;
    assign byte_err_valid = byte_err_valid_r;
    assign sync_lost      = sync_lost_r;

endmodule

// File: tb/tb_ber_checker.sv
// Self-checking bench for ber_checker: a 32-bit and an 8-bit counter instance
// share one stimulus stream and are compared every cycle against a byte-level model.
module tb_ber_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic       clear = 1'b0;

    logic        a_locked, a_bev, a_sl, b_locked, b_bev, b_sl;
    logic [3:0]  a_be, b_be;
    logic [31:0] a_err, a_bit;
    logic [7:0]  b_err, b_bit;

    always #5 clk = ~clk;

    ber_checker u_dut_a (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .clear(clear),
        .locked(a_locked), .byte_err(a_be), .byte_err_valid(a_bev), .sync_lost(a_sl),
        .err_count(a_err), .bit_count(a_bit)
    );

    ber_checker #(.CNT_W(8)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .clear(clear),
        .locked(b_locked), .byte_err(b_be), .byte_err_valid(b_bev), .sync_lost(b_sl),
        .err_count(b_err), .bit_count(b_bit)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int n_strobe = 0, n_be1 = 0, n_sl = 0, n_lockhi = 0;

    // Reference model state
    bit         m_locked;
    int         m_match, m_loss;
    logic [6:0] m_prev, m_lfsr;
    longint     m_err_a, m_bit_a, m_err_b, m_bit_b;
    logic [3:0] e_be;
    bit         e_bev, e_sl;

    // Serial PRBS-7 source bits, oldest first
    bit sq[$];

    function automatic logic [7:0] gen_byte();
        logic [7:0] r;
        bit nb;
        for (int i = 7; i >= 0; i--) begin
            nb = sq[sq.size() - 6] ^ sq[sq.size() - 7];
            sq.push_back(nb);
            r[i] = nb;
        end
        while (sq.size() > 7) void'(sq.pop_front());
        return r;
    endfunction

    function automatic logic [7:0] ref_pred(input logic [6:0] seed);
        bit s[15];
        logic [7:0] r;
        for (int k = 0; k < 7; k++) s[k] = seed[6-k];
        for (int n = 7; n < 15; n++) s[n] = s[n-6] ^ s[n-7];
        for (int k = 0; k < 8; k++) r[7-k] = s[7+k];
        return r;
    endfunction

    function automatic longint sat(input longint v, input longint a, input longint mx);
        return (v + a > mx) ? mx : v + a;
    endfunction

    task automatic model_reset();
        m_locked = 1'b0; m_match = 0; m_loss = 0; m_prev = 7'h00; m_lfsr = 7'h00;
        m_err_a = 0; m_bit_a = 0; m_err_b = 0; m_bit_b = 0;
        e_be = 4'd0; e_bev = 1'b0; e_sl = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] d, input bit v, input bit clr);
        logic [7:0] e;
        int be;
        bit was_locked;
        was_locked = m_locked;
        e_bev = 1'b0;
        e_sl  = 1'b0;
        if (clr) begin
            m_err_a = 0; m_bit_a = 0; m_err_b = 0; m_bit_b = 0;
        end
        if (!was_locked) begin
            e_be = 4'd0;
            if (v) begin
                e = ref_pred(m_prev);
                if (d == e && m_prev != 7'h00) begin
                    if (m_match == 7) begin
                        m_locked = 1'b1; m_lfsr = d[6:0]; m_match = 0;
                    end else begin
                        m_match++;
                    end
                end else begin
                    m_match = 0;
                end
                m_prev = d[6:0];
            end
        end else if (v) begin
            e = ref_pred(m_lfsr);
            m_lfsr = e[6:0];
            be = $countones(d ^ e);
            e_be = 4'(be);
            e_bev = 1'b1;
            if (!clr) begin
                m_err_a = sat(m_err_a, be, 64'hFFFF_FFFF); m_bit_a = sat(m_bit_a, 8, 64'hFFFF_FFFF);
                m_err_b = sat(m_err_b, be, 255);           m_bit_b = sat(m_bit_b, 8, 255);
            end
            if (be >= 3) begin
                m_loss++;
                if (m_loss == 4) begin
                    m_locked = 1'b0; e_sl = 1'b1; m_match = 0; m_loss = 0; m_prev = d[6:0];
                end
            end else begin
                m_loss = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_all();
        chk("locked", 32'(a_locked), 32'(m_locked));
        chk("byte_err_valid", 32'(a_bev), 32'(e_bev));
        chk("byte_err", 32'(a_be), 32'(e_be));
        chk("sync_lost", 32'(a_sl), 32'(e_sl));
        chk("err_count", a_err, m_err_a[31:0]);
        chk("bit_count", a_bit, m_bit_a[31:0]);
        chk("locked_w8", 32'(b_locked), 32'(m_locked));
        chk("err_count_w8", 32'(b_err), m_err_b[31:0]);
        chk("bit_count_w8", 32'(b_bit), m_bit_b[31:0]);
        if (a_bev) n_strobe++;
        if (a_bev && a_be == 4'd1) n_be1++;
        if (a_sl) n_sl++;
        if (a_locked) n_lockhi++;
    endtask

    task automatic tick(input logic [7:0] d, input bit v, input bit clr);
        @(negedge clk);
        din = d; din_valid = v; clear = clr;
        model_step(d, v, clr);
        @(posedge clk);
        #1;
        check_all();
    endtask

    // One valid byte, sometimes preceded by an idle cycle carrying junk data
    task automatic send(input logic [7:0] d);
        if ($urandom_range(0, 4) == 0) tick(8'($urandom), 1'b0, 1'b0);
        tick(d, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        din_valid = 1'b0; clear = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic relock9();
        for (int i = 1; i <= 9; i++) begin
            send(gen_byte());
            if (i == 8) chk("relock_b8", 32'(a_locked), 32'd0);
            if (i == 9) chk("relock_b9", 32'(a_locked), 32'd1);
        end
    endtask

    initial begin
        for (int i = 0; i < 7; i++) sq.push_back(1'b1);
        model_reset();
        do_reset();

        // Clean stream seeded 7'h7F
        for (int i = 1; i <= 100; i++) begin
            send(gen_byte());
            if (i == 8) chk("lock_b8", 32'(a_locked), 32'd0);
            if (i == 9) chk("lock_b9", 32'(a_locked), 32'd1);
        end
        chk("clean_strobes", 32'(n_strobe), 32'd91);
        chk("clean_bits", a_bit, 32'd728);
        chk("clean_errs", a_err, 32'd0);

        // Single-bit error every 10th byte
        n_strobe = 0; n_be1 = 0; n_sl = 0;
        for (int i = 1; i <= 100; i++) send(((i % 10) == 0) ? (gen_byte() ^ 8'h01) : gen_byte());
        chk("single_be1", 32'(n_be1), 32'd10);
        chk("single_strobes", 32'(n_strobe), 32'd100);
        chk("single_errs", a_err, 32'd10);
        chk("single_locked", 32'(a_locked), 32'd1);
        chk("single_nosl", 32'(n_sl), 32'd0);

        // Loss of sync after four bad bytes, then relock
        tick(8'h00, 1'b0, 1'b1);
        n_sl = 0;
        for (int i = 0; i < 4; i++) send(gen_byte() ^ 8'h0F);
        chk("loss_sl", 32'(n_sl), 32'd1);
        chk("loss_locked", 32'(a_locked), 32'd0);
        chk("loss_errs", a_err, 32'd16);
        relock9();

        // Random garbage: model decides whatever lock behaviour follows
        for (int i = 0; i < 30; i++) send(8'($urandom));

        // All-zero input never locks
        do_reset();
        n_lockhi = 0;
        for (int i = 0; i < 50; i++) send(8'h00);
        chk("zero_nolock", 32'(n_lockhi), 32'd0);
        chk("zero_errs", a_err, 32'd0);
        chk("zero_bits", a_bit, 32'd0);

        // Saturation of the 8-bit instance, loss burst, then clear with a valid byte
        tick(8'h00, 1'b0, 1'b1);
        relock9();
        for (int i = 0; i < 48; i++) send(((i % 4) != 3) ? (gen_byte() ^ 8'hFF) : gen_byte());
        chk("sat_errs_w8", 32'(b_err), 32'd255);
        chk("sat_bits_w8", 32'(b_bit), 32'd255);
        chk("sat_locked", 32'(a_locked), 32'd1);
        n_sl = 0;
        for (int i = 0; i < 4; i++) send(gen_byte() ^ 8'hFF);
        chk("sat_burst_sl", 32'(n_sl), 32'd1);
        relock9();
        tick(gen_byte(), 1'b1, 1'b1);
        chk("clear_errs", a_err, 32'd0);
        chk("clear_bits", a_bit, 32'd0);
        chk("clear_errs_w8", 32'(b_err), 32'd0);
        chk("clear_bits_w8", 32'(b_bit), 32'd0);
        chk("clear_locked", 32'(a_locked), 32'd1);

        // Reset while locked, then relock
        for (int i = 0; i < 5; i++) send(gen_byte());
        do_reset();
        chk("rst_locked", 32'(a_locked), 32'd0);
        chk("rst_bits", a_bit, 32'd0);
        relock9();
        tick(8'h00, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
